morse_tx_arbiter: RTL and testbench

- Shares one Morse LED encoder (char_vald / charcode_data / charlen_data / char_next handshake) between two message sources.
- Each source pushes pre-encoded characters into a private FIFO; the block arbitrates round-robin at message granularity and sequences characters to the encoder one at a time.
- Includes a watchdog that aborts a message if the encoder stops answering.

---
 rtl/morse_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_morse_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_arbiter.sv
// morse_tx_arbiter: two-source FIFO front end sharing one Morse encoder, message-granular round robin with watchdog
module morse_tx_arbiter #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4095
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_wr,
    input  logic [11:0] req0_data,
    input  logic        req0_last,
    output logic        req0_full,
    input  logic        req1_wr,
    input  logic [11:0] req1_data,
    input  logic        req1_last,
    output logic        req1_full,
    output logic        char_vald,
    output logic [7:0]  charcode_data,
    output logic [3:0]  charlen_data,
    input  logic        char_next,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FLUSH} state_t;

    state_t        state;
    logic          owner;
    logic          prio;
    logic          last_q;
    logic          next_q;
    logic          sel;
    logic [WW-1:0] wd;
    logic [1:0]    wr_in;
    logic [1:0]    full;
    logic [1:0]    empty;
    logic [1:0]    pop;
    logic [1:0]    owner_mask;
    logic [12:0]   din  [2];
    logic [12:0]   dout [2];

    assign wr_in      = {req1_wr, req0_wr};
    assign din[0]     = {req0_last, req0_data};
    assign din[1]     = {req1_last, req1_data};
    assign req0_full  = full[0];
    assign req1_full  = full[1];
    assign busy       = state != IDLE;
    assign owner_mask = owner ? 2'b10 : 2'b01;
    // with both queues waiting the pointer decides, otherwise take the non-empty one
    assign sel        = (!empty[0] && !empty[1]) ? prio : empty[0];

    for (genvar g = 0; g < 2; g++) begin : fifo
        logic [12:0]   mem [DEPTH];
        logic [AW-1:0] wp;
        logic [AW-1:0] rp;
        logic [AW:0]   cnt;
        logic          push;

        // fullness is judged before this cycle's pop, so a write on a full queue is lost
        assign push     = wr_in[g] && !full[g];
        assign pop[g]   = (state == LOAD || state == FLUSH) && owner_mask[g] && !empty[g];
        assign full[g]  = cnt == (AW + 1)'(DEPTH);
        assign empty[g] = cnt == '0;
        assign dout[g]  = mem[rp];

        // storage array, no reset needed since occupancy gates every read
        always_ff @(posedge clock)
            if (push) mem[wp] <= din[g];

        // queue pointers and occupancy
        always_ff @(posedge clock or posedge reset)
            if (reset) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop[g]) rp <= rp + 1'b1;
                cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop[g]};
            end
    end

    // message sequencer: grant, per-character handshake, watchdog and abort flush
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            prio          <= 1'b0;
            grant         <= 2'b00;
            last_q        <= 1'b0;
            next_q        <= 1'b0;
            char_vald     <= 1'b0;
            charcode_data <= '0;
            charlen_data  <= '0;
            wd            <= '0;
            timeout_err   <= 1'b0;
        end else begin
            next_q <= char_next;
            if (err_clr) timeout_err <= 1'b0;
            case (state)
                IDLE:
                    if (!(&empty)) begin
                        owner <= sel;
                        grant <= sel ? 2'b10 : 2'b01;
                        state <= LOAD;
                    end
                LOAD:
                    if (!empty[owner]) begin
                        {last_q, charcode_data, charlen_data} <= dout[owner];
                        char_vald <= 1'b1;
                        state     <= ISSUE;
                    end
                ISSUE: begin
                    char_vald <= 1'b0;
                    wd        <= '0;
                    state     <= WAIT;
                end
                WAIT:
                    if (char_next && !next_q) begin
                        if (last_q) begin
                            grant <= 2'b00;
                            prio  <= ~owner;
                            state <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (wd == WW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        if (last_q) begin
                            grant <= 2'b00;
                            prio  <= ~owner;
                            state <= IDLE;
                        end else begin
                            state <= FLUSH;
                        end
                    end else begin
                        wd <= (wd < WW'(TIMEOUT)) ? wd + 1'b1 : wd;
                    end
                FLUSH:
                    if (!empty[owner] && dout[owner][12]) begin
                        grant <= 2'b00;
                        prio  <= ~owner;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_morse_tx_arbiter.sv
// tb_morse_tx_arbiter: directed vectors with a delayed-answer encoder model and a pulse log
module tb_morse_tx_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_wr = 1'b0, req0_last = 1'b0, req1_wr = 1'b0, req1_last = 1'b0;
    logic [11:0] req0_data = '0, req1_data = '0;
    logic        req0_full, req1_full, char_vald, busy, timeout_err;
    logic [7:0]  charcode_data;
    logic [3:0]  charlen_data;
    logic [1:0]  grant;
    logic        char_next = 1'b0;
    logic        err_clr = 1'b0;
    logic        enc_en = 1'b0;
    int          kick_req = 0, kick_done = 0;
    int          n_vec = 0, n_bad = 0, dbl = 0, unstable = 0;
    logic        prev_cv = 1'b0;
    logic [11:0] ref_out = '0;
    logic [13:0] lg [$];

    morse_tx_arbiter #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .req0_wr(req0_wr), .req0_data(req0_data), .req0_last(req0_last), .req0_full(req0_full),
        .req1_wr(req1_wr), .req1_data(req1_data), .req1_last(req1_last), .req1_full(req1_full),
        .char_vald(char_vald), .charcode_data(charcode_data), .charlen_data(charlen_data),
        .char_next(char_next), .grant(grant), .busy(busy), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    // log every strobe as {grant, code, len}; flag wide strobes and data moving between strobes
    always @(negedge clock) begin
        if (reset) begin
            prev_cv = 1'b0;
            ref_out = '0;
        end else begin
            if (char_vald) begin
                lg.push_back({grant, charcode_data, charlen_data});
                if (prev_cv) dbl++;
                ref_out = {charcode_data, charlen_data};
            end else if ({charcode_data, charlen_data} != ref_out) begin
                unstable++;
            end
            prev_cv = char_vald;
        end
    end

    // encoder model: answers 10 cycles after each strobe, or once on a manual kick
    always begin
        @(negedge clock);
        if (kick_req != kick_done) begin
            kick_done = kick_req;
            char_next = 1'b1;
            @(negedge clock);
            char_next = 1'b0;
        end else if (enc_en && char_vald && !reset) begin
            repeat (10) @(negedge clock);
            char_next = 1'b1;
            @(negedge clock);
            char_next = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [13:0] exp);
        check(tag, idx < lg.size() ? 32'(lg[idx]) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic wr(input logic w0, input logic [11:0] d0, input logic l0,
                      input logic w1, input logic [11:0] d1, input logic l1);
        req0_wr = w0; req0_data = d0; req0_last = l0;
        req1_wr = w1; req1_data = d1; req1_last = l1;
        @(negedge clock);
        req0_wr = 1'b0;
        req1_wr = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int q = 0;
        int n = 0;
        while (q < 3 && n < lim) begin
            @(negedge clock);
            n++;
            q = busy ? 0 : q + 1;
        end
        check(tag, 32'(q), 32'd3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge clock);
        check("rst_cv", 32'(char_vald), 32'd0);
        check("rst_data", 32'({charcode_data, charlen_data}), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_te", 32'(timeout_err), 32'd0);
        check("rst_full", 32'({req1_full, req0_full}), 32'd0);
        #2 reset = 1'b0;
        @(negedge clock);

        // single message T then A, two-cycle latency to the first strobe
        enc_en = 1'b1;
        lg.delete();
        wr(1'b1, 12'h801, 1'b0, 1'b0, 12'h000, 1'b0);
        wr(1'b1, 12'h402, 1'b1, 1'b0, 12'h000, 1'b0);
        check("p1_cv_early", 32'(char_vald), 32'd0);
        @(negedge clock);
        check("p1_latency", 32'(char_vald), 32'd1);
        check("p1_grant", 32'(grant), 32'd1);
        wait_idle("p1_idle", 200);
        check("p1_count", 32'(lg.size()), 32'd2);
        chk_log("p1_char0", 0, {2'b01, 12'h801});
        chk_log("p1_char1", 1, {2'b01, 12'h402});
        check("p1_release", 32'(grant), 32'd0);

        // fill while stalled: 1 in the output register + 8 queued, 10th write dropped
        enc_en = 1'b0;
        lg.delete();
        for (int i = 0; i < 10; i++) begin
            wr(1'b1, {8'(8'h10 + i), 4'(i)}, 1'(i >= 8), 1'b0, 12'h000, 1'b0);
            if (i == 7) check("p2_not_full", 32'(req0_full), 32'd0);
            if (i == 8) check("p2_full", 32'(req0_full), 32'd1);
        end
        check("p2_full_drop", 32'(req0_full), 32'd1);
        kick_req++;
        enc_en = 1'b1;
        wait_idle("p2_idle", 400);
        check("p2_count", 32'(lg.size()), 32'd9);
        for (int i = 0; i < 9; i++) chk_log("p2_drain", i, {2'b01, 8'(8'h10 + i), 4'(i)});
        check("p2_empty", 32'(req0_full), 32'd0);

        // watchdog: 16 silent WAIT cycles, then the rest of the message is flushed
        enc_en = 1'b0;
        lg.delete();
        wr(1'b1, 12'hC02, 1'b0, 1'b0, 12'h000, 1'b0);
        wr(1'b1, 12'h803, 1'b0, 1'b0, 12'h000, 1'b0);
        wr(1'b1, 12'h104, 1'b1, 1'b0, 12'h000, 1'b0);
        check("p3_cv", 32'(char_vald), 32'd1);
        repeat (16) @(negedge clock);
        check("p3_te_early", 32'(timeout_err), 32'd0);
        @(negedge clock);
        check("p3_te_set", 32'(timeout_err), 32'd1);
        repeat (3) @(negedge clock);
        check("p3_grant", 32'(grant), 32'd0);
        check("p3_busy", 32'(busy), 32'd0);
        check("p3_no_strobe", 32'(lg.size()), 32'd1);

        // asynchronous reset in the middle of WAIT with entries still queued
        lg.delete();
        wr(1'b1, 12'h211, 1'b0, 1'b0, 12'h000, 1'b0);
        wr(1'b1, 12'h222, 1'b0, 1'b0, 12'h000, 1'b0);
        wr(1'b1, 12'h233, 1'b0, 1'b0, 12'h000, 1'b0);
        wr(1'b1, 12'h244, 1'b0, 1'b0, 12'h000, 1'b0);
        repeat (3) @(negedge clock);
        check("p4_pre_busy", 32'(busy), 32'd1);
        check("p4_pre_grant", 32'(grant), 32'd1);
        check("p4_pre_te", 32'(timeout_err), 32'd1);
        reset = 1'b1;
        #1;
        check("p4_cv", 32'(char_vald), 32'd0);
        check("p4_grant", 32'(grant), 32'd0);
        check("p4_busy", 32'(busy), 32'd0);
        check("p4_te", 32'(timeout_err), 32'd0);
        check("p4_full", 32'(req0_full), 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (6) @(negedge clock);
        check("p4_discarded", 32'(busy), 32'd0);
        enc_en = 1'b1;
        lg.delete();
        wr(1'b1, 12'hE03, 1'b1, 1'b0, 12'h000, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("p4_post_latency", 32'(char_vald), 32'd1);
        wait_idle("p4_idle", 200);
        check("p4_post_count", 32'(lg.size()), 32'd1);
        chk_log("p4_post_char", 0, {2'b01, 12'hE03});

        // timeout on a last entry releases straight away; err_clr clears the sticky flag
        enc_en = 1'b0;
        lg.delete();
        wr(1'b1, 12'h558, 1'b1, 1'b0, 12'h000, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("p5_cv", 32'(char_vald), 32'd1);
        repeat (16) @(negedge clock);
        check("p5_te_early", 32'(timeout_err), 32'd0);
        @(negedge clock);
        check("p5_te_set", 32'(timeout_err), 32'd1);
        check("p5_grant", 32'(grant), 32'd0);
        check("p5_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("p5_te_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        check("p5_te_clr", 32'(timeout_err), 32'd0);

        // contention after reset: req0 first, and a space (len 0) goes through
        do_reset();
        enc_en = 1'b1;
        lg.delete();
        wr(1'b1, 12'hC02, 1'b0, 1'b1, 12'hA04, 1'b0);
        wr(1'b1, 12'h003, 1'b1, 1'b1, 12'h000, 1'b1);
        wait_idle("p6_idle", 300);
        check("p6_count", 32'(lg.size()), 32'd4);
        chk_log("p6_c0", 0, {2'b01, 12'hC02});
        chk_log("p6_c1", 1, {2'b01, 12'h003});
        chk_log("p6_c2", 2, {2'b10, 12'hA04});
        chk_log("p6_c3", 3, {2'b10, 12'h000});

        // a lone req0 message hands the pointer to req1
        lg.delete();
        wr(1'b1, 12'h6A2, 1'b1, 1'b0, 12'h000, 1'b0);
        wait_idle("p7_idle", 200);
        chk_log("p7_c0", 0, {2'b01, 12'h6A2});

        // repeated contention: req1 now goes first
        lg.delete();
        wr(1'b1, 12'h311, 1'b0, 1'b1, 12'h722, 1'b0);
        wr(1'b1, 12'h333, 1'b1, 1'b1, 12'h744, 1'b1);
        wait_idle("p8_idle", 300);
        check("p8_count", 32'(lg.size()), 32'd4);
        chk_log("p8_c0", 0, {2'b10, 12'h722});
        chk_log("p8_c1", 1, {2'b10, 12'h744});
        chk_log("p8_c2", 2, {2'b01, 12'h311});
        chk_log("p8_c3", 3, {2'b01, 12'h333});

        // starvation: req0 holds the grant mid-message while req1 waits
        lg.delete();
        wr(1'b1, 12'h901, 1'b0, 1'b0, 12'h000, 1'b0);
        repeat (20) @(negedge clock);
        wr(1'b0, 12'h000, 1'b0, 1'b1, 12'hB02, 1'b0);
        wr(1'b0, 12'h000, 1'b0, 1'b1, 12'hB13, 1'b1);
        repeat (30) @(negedge clock);
        check("p9_hold_grant", 32'(grant), 32'd1);
        check("p9_hold_busy", 32'(busy), 32'd1);
        check("p9_hold_count", 32'(lg.size()), 32'd1);
        wr(1'b1, 12'h9F4, 1'b1, 1'b0, 12'h000, 1'b0);
        wait_idle("p9_idle", 300);
        check("p9_count", 32'(lg.size()), 32'd4);
        chk_log("p9_c0", 0, {2'b01, 12'h901});
        chk_log("p9_c1", 1, {2'b01, 12'h9F4});
        chk_log("p9_c2", 2, {2'b10, 12'hB02});
        chk_log("p9_c3", 3, {2'b10, 12'hB13});

        check("strobe_width", 32'(dbl), 32'd0);
        check("data_stable", 32'(unstable), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
